wb_stage: RTL and testbench

//  Writeback stage of the RV32I pipeline, directly downstream of the memory stage.
//  - Accepts one instruction per transfer from MEM and, for loads, waits for the data-cache response.
//  - Aligns and extends load data, selects the register-file write value, and commits it one cycle later.
//  - Provides forwarding values, a retired-instruction counter and a load-stall counter.

---
 rtl/wb_stage.sv | 153 +++++++++++++++
 tb/tb_wb_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// RV32I writeback stage: aligns load data, selects the register-file write value,
// commits it one cycle later, and keeps retire / load-stall counters.
module wb_stage #(
  parameter int CNT_W   = 64,
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_alu,
  input  logic [31:0]        in_br,
  input  logic [31:0]        in_u_imm,
  input  logic [4:0]         in_rd,
  input  logic               in_ld_rf,
  input  logic [2:0]         in_rfmux_sel,
  input  logic [2:0]         in_funct3,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_resp,
  output logic               rf_load,
  output logic [4:0]         rf_rd,
  output logic [31:0]        rf_wdata,
  output logic               retire_valid,
  output logic [31:0]        retire_pc,
  output logic [CNT_W-1:0]   instret,
  output logic [STALL_W-1:0] load_stalls
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [2:0] SEL_LOAD = 3'd3;

  state_t      state;
  logic [31:0] pc_p0, alu_p0, br_p0, u_imm_p0;
  logic [4:0]  rd_p0;
  logic        ld_rf_p0;
  logic [2:0]  sel_p0, funct3_p0;

  function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                             input logic [1:0]  a,
                                             input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'h0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'h0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] wb_select(input logic [2:0]  sel,
                                            input logic [31:0] pc,
                                            input logic [31:0] alu,
                                            input logic [31:0] br,
                                            input logic [31:0] u_imm,
                                            input logic [31:0] ld);
    case (sel)
      3'd1:    return br;
      3'd2:    return u_imm;
      3'd3:    return ld;
      3'd4:    return pc + 32'd4;
      default: return alu;
    endcase
  endfunction

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  // In WAIT the captured fields drive the datapath; in IDLE the live inputs do.
  logic        in_wait, xfer, is_load, commit, go_wait;
  logic [31:0] cur_pc, cur_alu, cur_br, cur_u_imm, ld_val_p0, wdata_p0;
  logic [4:0]  cur_rd;
  logic        cur_ld_rf;
  logic [2:0]  cur_sel, cur_funct3;

  assign in_wait    = (state == WAIT);
  assign in_ready   = ~in_wait;
  assign xfer       = in_valid & in_ready;
  assign is_load    = (in_rfmux_sel == SEL_LOAD);
  assign commit     = ~flush & ((xfer & (~is_load | dmem_resp)) | (in_wait & dmem_resp));
  assign go_wait    = ~flush & xfer & is_load & ~dmem_resp;

  assign cur_pc     = in_wait ? pc_p0     : in_pc;
  assign cur_alu    = in_wait ? alu_p0    : in_alu;
  assign cur_br     = in_wait ? br_p0     : in_br;
  assign cur_u_imm  = in_wait ? u_imm_p0  : in_u_imm;
  assign cur_rd     = in_wait ? rd_p0     : in_rd;
  assign cur_ld_rf  = in_wait ? ld_rf_p0  : in_ld_rf;
  assign cur_sel    = in_wait ? sel_p0    : in_rfmux_sel;
  assign cur_funct3 = in_wait ? funct3_p0 : in_funct3;

  assign ld_val_p0  = load_align(dmem_rdata, cur_alu[1:0], cur_funct3);
  assign wdata_p0   = wb_select(cur_sel, cur_pc, cur_alu, cur_br, cur_u_imm, ld_val_p0);

  always_ff @(posedge clk) begin
    if (go_wait) begin
      pc_p0     <= in_pc;
      alu_p0    <= in_alu;
      br_p0     <= in_br;
      u_imm_p0  <= in_u_imm;
      rd_p0     <= in_rd;
      ld_rf_p0  <= in_ld_rf;
      sel_p0    <= in_rfmux_sel;
      funct3_p0 <= in_funct3;
    end
  end

  // p0 -> p1: commit registers, FSM and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rf_load      <= 1'b0;
      rf_rd        <= '0;
      rf_wdata     <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      instret      <= '0;
      load_stalls  <= '0;
    end else begin
      if (in_wait && !dmem_resp)
        load_stalls <= sat_inc(load_stalls);
      if (flush)
        state <= IDLE;
      else if (go_wait)
        state <= WAIT;
      else if (in_wait && dmem_resp)
        state <= IDLE;
      rf_load      <= commit & cur_ld_rf & (cur_rd != 5'd0);
      retire_valid <= commit;
      if (commit) begin
        rf_rd     <= cur_rd;
        rf_wdata  <= wdata_p0;
        retire_pc <= cur_pc;
        instret   <= instret + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized bench for wb_stage against a transaction-level model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_alu, in_br, in_u_imm, dmem_rdata;
  logic [4:0]  in_rd;
  logic        in_ld_rf, dmem_resp;
  logic [2:0]  in_rfmux_sel, in_funct3;
  logic        rf_load, retire_valid;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata, retire_pc;
  logic [63:0] instret;
  logic [31:0] load_stalls;

  wb_stage #(.CNT_W(64), .STALL_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu(in_alu), .in_br(in_br), .in_u_imm(in_u_imm), .in_rd(in_rd),
    .in_ld_rf(in_ld_rf), .in_rfmux_sel(in_rfmux_sel), .in_funct3(in_funct3),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .rf_load(rf_load), .rf_rd(rf_rd),
    .rf_wdata(rf_wdata), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .instret(instret), .load_stalls(load_stalls)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc, alu, br, u_imm;
    logic [4:0]  rd;
    logic        ld_rf;
    logic [2:0]  sel, f3;
  } instr_t;

  // Reference state: an optional outstanding load plus expected outputs.
  instr_t      pending[$];
  logic        e_rf_load, e_rv;
  logic [4:0]  e_rf_rd;
  logic [31:0] e_wdata, e_rpc, e_stalls;
  logic [63:0] e_instret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [31:0] addr,
                                           input logic [2:0] f3);
    int unsigned v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (d >> (8 * addr[1:0])) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (d >> (16 * addr[1])) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    end else v = d;
    return v;
  endfunction

  function automatic logic [31:0] ref_value(input instr_t t, input logic [31:0] d);
    case (t.sel)
      3'd1: return t.br;
      3'd2: return t.u_imm;
      3'd3: return ref_load(d, t.alu, t.f3);
      3'd4: return t.pc + 32'd4;
      default: return t.alu;
    endcase
  endfunction

  task automatic model_reset();
    pending.delete();
    e_rf_load = 0; e_rv = 0; e_rf_rd = 0; e_wdata = 0; e_rpc = 0;
    e_instret = 0; e_stalls = 0;
  endtask

  task automatic retire(input instr_t t);
    e_rv = 1; e_rpc = t.pc; e_instret = e_instret + 1;
    e_rf_load = t.ld_rf && (t.rd != 0); e_rf_rd = t.rd;
    e_wdata = ref_value(t, dmem_rdata);
  endtask

  task automatic model_step();
    instr_t cur;
    e_rv = 0; e_rf_load = 0;
    if (pending.size() != 0 && !dmem_resp && e_stalls != 32'hFFFF_FFFF) e_stalls++;
    if (flush) pending.delete();
    else if (pending.size() != 0) begin
      if (dmem_resp) retire(pending.pop_front());
    end else if (in_valid) begin
      cur = '{in_pc, in_alu, in_br, in_u_imm, in_rd, in_ld_rf, in_rfmux_sel, in_funct3};
      if (cur.sel == 3'd3 && !dmem_resp) pending.push_back(cur);
      else retire(cur);
    end
  endtask

  task automatic check_all();
    check("in_ready", in_ready, pending.size() == 0);
    check("rf_load", rf_load, e_rf_load);
    check("retire_valid", retire_valid, e_rv);
    check("rf_rd", rf_rd, e_rf_rd);
    check("rf_wdata", rf_wdata, e_wdata);
    check("retire_pc", retire_pc, e_rpc);
    check("instret", instret, e_instret);
    check("load_stalls", load_stalls, e_stalls);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] rdata, input logic resp, input logic fl);
    in_valid = v; in_rfmux_sel = sel; in_pc = pc; in_alu = alu; in_rd = rd;
    in_funct3 = f3; dmem_rdata = rdata; dmem_resp = resp; flush = fl;
    in_ld_rf = 1'b1; in_br = 32'h1; in_u_imm = 32'hABCD_E000;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [63:0] snap;

  initial begin
    rst_n = 0;
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    drive(1, 3'd0, 32'h100, 32'h1234, 5'd5, 3'd0, 0, 0, 0);
    cycle();
    check("add_rf_load", rf_load, 1);
    check("add_rf_rd", rf_rd, 5);
    check("add_wdata", rf_wdata, 32'h1234);
    check("add_instret", instret, 1);

    drive(1, 3'd3, 32'h104, 32'h203, 5'd6, 3'd0, 32'h80FF_FFFF, 1, 0);
    cycle();
    check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    drive(1, 3'd3, 32'h108, 32'h203, 5'd6, 3'd4, 32'h80FF_FFFF, 1, 0);
    cycle();
    check("lbu_wdata", rf_wdata, 32'h0000_0080);

    drive(1, 3'd3, 32'h10C, 32'h302, 5'd7, 3'd5, 32'h0, 0, 0);
    cycle();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      check("lhu_wait_ready", in_ready, 0);
      cycle();
    end
    check("lhu_resp_ready", in_ready, 0);
    drive(0, 3'd0, 0, 0, 0, 0, 32'h80FF_0000, 1, 0);
    cycle();
    check("lhu_wdata", rf_wdata, 32'h0000_80FF);
    check("lhu_stalls", load_stalls, 3);
    check("lhu_ready_after", in_ready, 1);

    drive(1, 3'd4, 32'hFFFF_FFFC, 32'h0, 5'd1, 3'd0, 0, 0, 0);
    cycle();
    check("jal_wrap", rf_wdata, 32'h0);
    drive(1, 3'd4, 32'hFFFF_FFFC, 32'h0, 5'd0, 3'd0, 0, 0, 0);
    cycle();
    check("jal_x0_load", rf_load, 0);
    check("jal_x0_retire", retire_valid, 1);

    drive(1, 3'd3, 32'h200, 32'h400, 5'd9, 3'd2, 0, 0, 0);
    cycle();
    snap = instret;
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    drive(0, 3'd0, 0, 0, 0, 0, 32'h5555_5555, 1, 0);
    cycle();
    check("flush_no_retire", retire_valid, 0);
    check("flush_instret", instret, snap);
    check("flush_ready", in_ready, 1);

    drive(1, 3'd3, 32'h204, 32'h400, 5'd9, 3'd2, 0, 0, 0);
    cycle();
    drive(0, 3'd0, 0, 0, 0, 0, 32'h1111_1111, 1, 1);
    cycle();
    check("flush_resp_drop", retire_valid, 0);

    drive(1, 3'd3, 32'h208, 32'h400, 5'd9, 3'd2, 0, 0, 0);
    cycle();
    idle_in();
    cycle();
    rst_n = 0;
    #2;
    model_reset();
    check_all();
    check("rst_wait_instret", instret, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    drive(0, 3'd0, 0, 0, 0, 0, 32'h2222_2222, 1, 0);
    cycle();
    check("stray_resp", retire_valid, 0);

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 60,
            ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(0, 7)),
            $urandom, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 1), $urandom_range(0, 99) < 5);
      in_ld_rf = $urandom_range(0, 1);
      in_br = $urandom_range(0, 1);
      in_u_imm = $urandom & 32'hFFFF_F000;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
